// File: rtl/bin2bcd_seq.sv
// Purpose : iterative binary-to-BCD converter (double dabble), one input bit per clock.
// Latency : start accepted at edge k -> done pulses for one cycle after edge k+BIN_W; BIN_W+2 cycles per result.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or done.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous reset, active-high
//   start - conversion request (sampled in IDLE only)
//   bin   - binary operand, captured on the accepting edge
//   busy  - high while bits are being shifted in
//   done  - one-cycle pulse; bcd/ovf hold the new result
//   bcd   - packed BCD result, digit 0 in bcd[3:0]
//   ovf   - value exceeded 10^DIGITS-1; bcd holds the low digits
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q,   state_d;
   logic [BIN_W-1:0]   shreg_q,   shreg_d;
   logic [BCD_W-1:0]   accum_q,   accum_d;
   logic               ovf_int_q, ovf_int_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [BCD_W-1:0]   bcd_q,     bcd_d;
   logic               ovf_q,     ovf_d;

   logic [BCD_W-1:0]   accum_adj;
   logic [BCD_W-1:0]   accum_shift;
   logic               shift_carry;

   // Add-3 correction on every digit so that the following left shift
   // (multiply by two) carries correctly into the next decimal digit.
   always_comb begin
      accum_adj = accum_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (accum_q[4*i +: 4] >= 4'd5) begin
            accum_adj[4*i +: 4] = accum_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // The bit leaving the top digit is lost; lower digits stay exact because
   // decimal carries only ever propagate upward, so it just flags overflow.
   always_comb begin
      shift_carry = accum_adj[BCD_W-1];
      accum_shift = {accum_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      accum_d   = accum_q;
      ovf_int_d = ovf_int_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d   = bin;
               accum_d   = '0;
               ovf_int_d = 1'b0;
               cnt_d     = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            accum_d   = accum_shift;
            shreg_d   = shreg_q << 1;
            ovf_int_d = ovf_int_q | shift_carry;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               bcd_d   = accum_shift;
               ovf_d   = ovf_int_q | shift_carry;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         accum_q   <= '0;
         ovf_int_q <= 1'b0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         accum_q   <= accum_d;
         ovf_int_q <= ovf_int_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   assign busy = (state_q == ST_SHIFT);
   assign done = (state_q == ST_DONE);
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule
